// File: rtl/mul_hash_combine.sv
// mul_hash_combine: recombines DSP partial products into a 64-bit product and queues its top bits as a hash index
module mul_hash_combine #(
  parameter int MUL_LAT    = 6,
  parameter int HASH_BITS  = 16,
  parameter int TAG_W      = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [1:0]           in_mode,
  input  logic [TAG_W-1:0]     in_tag,
  input  logic [31:0]          ab0,
  input  logic [31:0]          ab1,
  input  logic [31:0]          ab2,
  input  logic [31:0]          ab3,
  input  logic [31:0]          ab0_1sc,
  input  logic [31:0]          ab1_1sc,
  input  logic [31:0]          ab2_1sc,
  input  logic [31:0]          ab3_1sc,
  input  logic [23:0]          msk_ab0,
  input  logic [23:0]          msk_ab1,
  input  logic [23:0]          msk_ab2,
  input  logic [23:0]          msk_ab3,
  input  logic [23:0]          msk_ab0_1sc,
  input  logic [23:0]          msk_ab1_1sc,
  input  logic [23:0]          msk_ab2_1sc,
  input  logic [23:0]          msk_ab3_1sc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [HASH_BITS-1:0] out_hash,
  output logic [TAG_W-1:0]     out_tag,
  output logic [15:0]          drop_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [MUL_LAT-1:0]   sb_v;
  logic [1:0]           sb_m [MUL_LAT];
  logic [TAG_W-1:0]     sb_t [MUL_LAT];
  logic [31:0]          full [4];
  logic [31:0]          full_1sc [4];
  logic [23:0]          msk [4];
  logic [23:0]          msk_1sc [4];
  logic [31:0]          t [4];
  logic [1:0]           mode;
  logic                 s1_v, s2_v;
  logic [47:0]          s1_lo, s1_hi;
  logic [TAG_W-1:0]     s1_t, s2_t;
  logic [63:0]          s2_p;
  logic [HASH_BITS-1:0] hash;
  logic [HASH_BITS-1:0] mem_h [FIFO_DEPTH];
  logic [TAG_W-1:0]     mem_t [FIFO_DEPTH];
  logic [AW-1:0]        wr, rd, rd_n;
  logic [AW:0]          cnt, cnt_n;
  logic                 pop, push, drop, fwd;

  assign full     = '{ab0, ab1, ab2, ab3};
  assign full_1sc = '{ab0_1sc, ab1_1sc, ab2_1sc, ab3_1sc};
  assign msk      = '{msk_ab0, msk_ab1, msk_ab2, msk_ab3};
  assign msk_1sc  = '{msk_ab0_1sc, msk_ab1_1sc, msk_ab2_1sc, msk_ab3_1sc};
  assign mode     = sb_m[MUL_LAT-1];

  always_comb
    for (int i = 0; i < 4; i++)
      t[i] = mode == 2'd0 ? full[i] : mode == 2'd1 ? full_1sc[i] :
             mode == 2'd2 ? {8'd0, msk[i]} : {8'd0, msk_1sc[i]};

  assign hash  = s2_p[63 -: HASH_BITS];
  assign pop   = out_valid & out_ready;
  assign push  = s2_v & ((cnt != (AW+1)'(FIFO_DEPTH)) | pop);
  assign drop  = s2_v & ~push;
  assign rd_n  = rd + AW'(pop);
  assign cnt_n = cnt + (AW+1)'(push) - (AW+1)'(pop);
  // the new head is the entry being written when it lands exactly at the next read slot
  assign fwd   = push & (wr == rd_n);

  always_ff @(posedge clk) begin
    for (int i = MUL_LAT - 1; i > 0; i--) begin
      sb_m[i] <= sb_m[i-1];
      sb_t[i] <= sb_t[i-1];
    end
    sb_m[0] <= in_mode;
    sb_t[0] <= in_tag;
    s1_lo   <= {16'd0, t[0]} + {t[1], 16'd0};
    s1_hi   <= {16'd0, t[2]} + {t[3], 16'd0};
    s1_t    <= sb_t[MUL_LAT-1];
    s2_p    <= {16'd0, s1_lo} + {s1_hi[31:0], 32'd0};
    s2_t    <= s1_t;
    if (push) begin
      mem_h[wr] <= hash;
      mem_t[wr] <= s2_t;
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sb_v      <= '0;
      s1_v      <= 1'b0;
      s2_v      <= 1'b0;
      wr        <= '0;
      rd        <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_hash  <= '0;
      out_tag   <= '0;
      drop_cnt  <= '0;
    end else begin
      sb_v      <= MUL_LAT'({sb_v, in_valid});
      s1_v      <= sb_v[MUL_LAT-1];
      s2_v      <= s1_v;
      wr        <= wr + AW'(push);
      rd        <= rd_n;
      cnt       <= cnt_n;
      out_valid <= cnt_n != '0;
      out_hash  <= fwd ? hash : mem_h[rd_n];
      out_tag   <= fwd ? s2_t : mem_t[rd_n];
      drop_cnt  <= drop_cnt + 16'(drop && drop_cnt != 16'hFFFF);
    end
endmodule

// File: tb/tb_mul_hash_combine.sv
// tb_mul_hash_combine: emulates the DSP multiplier feeding the combiner and checks against a queue-based model
module tb_mul_hash_combine;
  localparam int M = 6;
  localparam int D = 8;
  localparam logic [63:0] B = 64'h0b4e0ef37bc32127;

  typedef struct { logic [15:0] a; logic [63:0] b; } key_t;
  typedef struct { logic v; logic [63:0] p; logic [15:0] t; } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid, out_ready;
  logic [1:0]  in_mode;
  logic [15:0] in_tag;
  logic [31:0] ab [4];
  logic [31:0] ab1 [4];
  logic [23:0] mab [4];
  logic [23:0] mab1 [4];
  logic        out_valid, v8;
  logic [15:0] out_hash, out_tag, drop_cnt, t8, d8;
  logic [7:0]  h8;

  key_t        dl [$];
  ent_t        pend [$];
  ent_t        fq [$];
  logic [15:0] drops;
  int          n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  mul_hash_combine #(.MUL_LAT(M), .HASH_BITS(16), .TAG_W(16), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_mode(in_mode), .in_tag(in_tag),
    .ab0(ab[0]), .ab1(ab[1]), .ab2(ab[2]), .ab3(ab[3]),
    .ab0_1sc(ab1[0]), .ab1_1sc(ab1[1]), .ab2_1sc(ab1[2]), .ab3_1sc(ab1[3]),
    .msk_ab0(mab[0]), .msk_ab1(mab[1]), .msk_ab2(mab[2]), .msk_ab3(mab[3]),
    .msk_ab0_1sc(mab1[0]), .msk_ab1_1sc(mab1[1]), .msk_ab2_1sc(mab1[2]), .msk_ab3_1sc(mab1[3]),
    .out_valid(out_valid), .out_ready(out_ready), .out_hash(out_hash), .out_tag(out_tag),
    .drop_cnt(drop_cnt));

  mul_hash_combine #(.MUL_LAT(M), .HASH_BITS(8), .TAG_W(16), .FIFO_DEPTH(D)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_mode(in_mode), .in_tag(in_tag),
    .ab0(ab[0]), .ab1(ab[1]), .ab2(ab[2]), .ab3(ab[3]),
    .ab0_1sc(ab1[0]), .ab1_1sc(ab1[1]), .ab2_1sc(ab1[2]), .ab3_1sc(ab1[3]),
    .msk_ab0(mab[0]), .msk_ab1(mab[1]), .msk_ab2(mab[2]), .msk_ab3(mab[3]),
    .msk_ab0_1sc(mab1[0]), .msk_ab1_1sc(mab1[1]), .msk_ab2_1sc(mab1[2]), .msk_ab3_1sc(mab1[3]),
    .out_valid(v8), .out_ready(out_ready), .out_hash(h8), .out_tag(t8), .drop_cnt(d8));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [63:0] prod(input logic [15:0] a, input logic [1:0] m, input logic [63:0] b);
    logic [15:0] op16 = m[0] ? ~a : a;
    logic [63:0] op = m[1] ? {56'd0, op16[15:8]} : {48'd0, op16};
    return op * b;
  endfunction

  task automatic model_clear();
    ent_t z = '{v: 1'b0, p: 64'd0, t: 16'd0};
    pend.delete();
    fq.delete();
    drops = 16'd0;
    repeat (M + 2) pend.push_back(z);
  endtask

  // one clock: drive this cycle's key, advance the model across the edge, compare after it
  task automatic step(input logic v, input logic [1:0] m, input logic [15:0] tg,
                      input logic [15:0] a, input logic [63:0] b, input logic rdy);
    key_t k;
    ent_t e;
    logic [15:0] na, bi;
    logic pop, full;
    in_valid = v; in_mode = m; in_tag = tg; out_ready = rdy;
    dl.push_back('{a: a, b: b});
    k = dl.pop_front();
    na = ~k.a;
    for (int i = 0; i < 4; i++) begin
      bi = k.b[16*i +: 16];
      ab[i]   = {16'd0, k.a} * {16'd0, bi};
      ab1[i]  = {16'd0, na} * {16'd0, bi};
      mab[i]  = {16'd0, k.a[15:8]} * {8'd0, bi};
      mab1[i] = {16'd0, na[15:8]} * {8'd0, bi};
    end
    pend.push_back('{v: v, p: prod(a, m, b), t: tg});
    e = pend.pop_front();
    full = fq.size() == D;
    pop = fq.size() != 0 && rdy;
    if (pop) void'(fq.pop_front());
    if (e.v) begin
      if (!full || pop) fq.push_back(e);
      else if (drops != 16'hFFFF) drops++;
    end
    @(posedge clk);
    #1;
    chk("valid", out_valid, fq.size() != 0);
    chk("valid8", v8, fq.size() != 0);
    chk("drop", drop_cnt, drops);
    if (fq.size() != 0) begin
      chk("hash", out_hash, fq[0].p[63:48]);
      chk("hash8", h8, fq[0].p[63:56]);
      chk("tag", out_tag, fq[0].t);
    end
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 2'd0, 16'd0, 16'd0, 64'd0, rdy);
  endtask

  task automatic rst_cyc(input int n);
    rst_n = 1'b0;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_hash", out_hash, 0);
    chk("rst_tag", out_tag, 0);
    chk("rst_drop", drop_cnt, 0);
    model_clear();
    repeat (n) idle(1'b1);
    rst_n = 1'b1;
  endtask

  task automatic one(input string tag, input logic [1:0] m, input logic [15:0] a, input logic [15:0] exp);
    step(1'b1, m, 16'h00A1, a, B, 1'b1);
    repeat (M + 1) idle(1'b1);
    chk({tag, "_early"}, out_valid, 0);
    idle(1'b1);
    chk({tag, "_on"}, out_valid, 1);
    chk(tag, out_hash, exp);
    chk({tag, "_8"}, h8, exp[15:8]);
    chk({tag, "_tag"}, out_tag, 16'h00A1);
    idle(1'b1);
  endtask

  initial begin
    logic [63:0] wrap;
    in_valid = 1'b0; in_mode = 2'd0; in_tag = 16'd0; out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin ab[i] = 0; ab1[i] = 0; mab[i] = 0; mab1[i] = 0; end
    repeat (M) dl.push_back('{a: 16'd0, b: 64'd0});
    #2;
    rst_cyc(3);
    one("t1", 2'd0, 16'h0001, 16'h0b4e);
    one("t2_full", 2'd0, 16'h0002, 16'h169c);
    one("t2_1sc", 2'd1, 16'hFFFE, 16'h0b4e);
    one("t3_msk", 2'd2, 16'h01FF, 16'h0b4e);
    one("t3_msk1sc", 2'd3, 16'hFEFF, 16'h0b4e);
    wrap = 64'hFFFF * B;
    one("t4_wrap", 2'd0, 16'hFFFF, wrap[63:48]);
    for (int i = 0; i < 12; i++)
      step(1'b1, 2'd0, 16'(16'h0100 + i), 16'($urandom), {$urandom, $urandom}, 1'b0);
    repeat (M + 3) idle(1'b0);
    chk("t5_drops", drop_cnt, 4);
    chk("t5_held", out_valid, 1);
    repeat (D) idle(1'b1);
    chk("t5_empty", out_valid, 0);
    model_clear();
    rst_cyc(1);
    for (int i = 0; i < 3; i++)
      step(1'b1, 2'(i), 16'(16'h0200 + i), 16'($urandom), {$urandom, $urandom}, 1'b1);
    rst_cyc(1);
    repeat (M + 4) idle(1'b1);
    chk("t6_empty", out_valid, 0);
    chk("t6_drop", drop_cnt, 0);
    for (int i = 0; i < 10000; i++)
      step($urandom_range(0, 4) != 0, 2'($urandom), 16'($urandom), 16'($urandom),
           {$urandom, $urandom}, $urandom_range(0, 3) != 0);
    repeat (M + D + 4) idle(1'b1);
    chk("final_empty", out_valid, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
